int_issue_exec: RTL and testbench

INT_ISSUE_EXEC -- requirements
Module: int_issue_exec

---
 rtl/int_issue_exec_pkg.sv | 17 +
 rtl/int_issue_exec_if.sv | 36 +++
 rtl/int_issue_exec_alu.sv | 37 +++
 rtl/int_issue_exec.sv | 87 ++++++++
 tb/tb_int_issue_exec.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/int_issue_exec_pkg.sv
// Shared integer-pipe definitions: ALU opcodes and default widths,
// used by dispatch, the integer issue queue and the execute unit.
package mips_int_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int TAG_W_DEF  = 5;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;
   localparam logic [2:0] ALU_SLL = 3'b101;
   localparam logic [2:0] ALU_SRL = 3'b110;
   localparam logic [2:0] ALU_SRA = 3'b111;

endpackage

// File: rtl/int_issue_exec_if.sv
// Issue-queue / CDB handshake bundle of the integer execute unit.
// master = queue/arbiter side, slave = execute unit.
interface int_issue_exec_if
   import mips_int_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int TAG_W  = TAG_W_DEF
);
   logic              IssueQue_Ready;
   logic [DATA_W-1:0] IssueQue_Rs_Data;
   logic [DATA_W-1:0] IssueQue_Rt_Data;
   logic [TAG_W-1:0]  IssueQue_Rd_Tag;
   logic [2:0]        IssueQue_Opcode;
   logic [4:0]        IssueQue_Shfamt;
   logic              Issueblk_Issue;
   logic              Int_Cdb_Req;
   logic [TAG_W-1:0]  Int_Cdb_Tag;
   logic [DATA_W-1:0] Int_Cdb_Data;
   logic              Cdb_Grant;
   logic              RB_Flush_Valid;

   modport master (
      output IssueQue_Ready, IssueQue_Rs_Data, IssueQue_Rt_Data,
             IssueQue_Rd_Tag, IssueQue_Opcode, IssueQue_Shfamt,
             Cdb_Grant, RB_Flush_Valid,
      input  Issueblk_Issue, Int_Cdb_Req, Int_Cdb_Tag, Int_Cdb_Data
   );

   modport slave (
      input  IssueQue_Ready, IssueQue_Rs_Data, IssueQue_Rt_Data,
             IssueQue_Rd_Tag, IssueQue_Opcode, IssueQue_Shfamt,
             Cdb_Grant, RB_Flush_Valid,
      output Issueblk_Issue, Int_Cdb_Req, Int_Cdb_Tag, Int_Cdb_Data
   );

endinterface

// File: rtl/int_issue_exec_alu.sv
// Combinational integer ALU. Shifts exist only with INT_EXEC_SHIFT_EN defined;
// otherwise opcodes 101-111 return zero.
module int_alu
   import mips_int_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
)(
   input  logic [2:0]        opcode,
   input  logic [4:0]        shfamt,
   input  logic [DATA_W-1:0] rs,
   input  logic [DATA_W-1:0] rt,
   output logic [DATA_W-1:0] result
);

`ifndef INT_EXEC_SHIFT_EN
   logic unused_shfamt;
   assign unused_shfamt = ^shfamt;
`endif

   always_comb begin
      result = '0;
      case (opcode)
         ALU_ADD: result = rs + rt;
         ALU_SUB: result = rs - rt;
         ALU_AND: result = rs & rt;
         ALU_OR:  result = rs | rt;
         ALU_SLT: result[0] = $signed(rs) < $signed(rt);
`ifdef INT_EXEC_SHIFT_EN
         ALU_SLL: result = rt << shfamt;
         ALU_SRL: result = rt >> shfamt;
         ALU_SRA: result = $signed(rt) >>> shfamt;
`endif
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/int_issue_exec.sv
// Two-stage integer execute unit (EX -> WB) between the issue queue and the CDB.
// Shifter is built only when INT_EXEC_SHIFT_EN is defined.
module int_issue_exec
   import mips_int_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int TAG_W  = TAG_W_DEF
)(
   input logic          Clk,
   input logic          Rst,
   int_issue_exec_if.slave bus
);

   logic              ex_valid;
   logic [2:0]        ex_opcode;
   logic [4:0]        ex_shfamt;
   logic [DATA_W-1:0] ex_rs;
   logic [DATA_W-1:0] ex_rt;
   logic [TAG_W-1:0]  ex_tag;

   logic              wb_valid;
   logic [TAG_W-1:0]  wb_tag;
   logic [DATA_W-1:0] wb_data;

   logic [DATA_W-1:0] alu_result;
   logic              wb_free;
   logic              ex_adv;
   logic              issue;

   int_alu #(.DATA_W(DATA_W)) u_alu (
      .opcode (ex_opcode),
      .shfamt (ex_shfamt),
      .rs     (ex_rs),
      .rt     (ex_rt),
      .result (alu_result)
   );

   // Rst gates issue so the queue never pops an entry while we are held in reset
   assign wb_free = ~wb_valid | bus.Cdb_Grant;
   assign ex_adv  = ex_valid & wb_free;
   assign issue   = bus.IssueQue_Ready & (~ex_valid | ex_adv) & ~bus.RB_Flush_Valid & ~Rst;

   assign bus.Issueblk_Issue = issue;
   assign bus.Int_Cdb_Req    = wb_valid;
   assign bus.Int_Cdb_Tag    = wb_tag;
   assign bus.Int_Cdb_Data   = wb_data;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         ex_valid  <= 1'b0;
         ex_opcode <= '0;
         ex_shfamt <= '0;
         ex_rs     <= '0;
         ex_rt     <= '0;
         ex_tag    <= '0;
      end else if (bus.RB_Flush_Valid) begin
         ex_valid <= 1'b0;
      end else if (issue) begin
         ex_valid  <= 1'b1;
         ex_opcode <= bus.IssueQue_Opcode;
         ex_shfamt <= bus.IssueQue_Shfamt;
         ex_rs     <= bus.IssueQue_Rs_Data;
         ex_rt     <= bus.IssueQue_Rt_Data;
         ex_tag    <= bus.IssueQue_Rd_Tag;
      end else if (ex_adv) begin
         ex_valid <= 1'b0;
      end
   end

   // A grant empties WB unless EX refills it on the same edge (back-to-back results)
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         wb_valid <= 1'b0;
         wb_tag   <= '0;
         wb_data  <= '0;
      end else if (bus.RB_Flush_Valid) begin
         wb_valid <= 1'b0;
      end else if (ex_adv) begin
         wb_valid <= 1'b1;
         wb_tag   <= ex_tag;
         wb_data  <= alu_result;
      end else if (bus.Cdb_Grant) begin
         wb_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_int_issue_exec.sv
// Scoreboard bench for int_issue_exec: issued instructions push their expected
// CDB payload, a negedge monitor pops and compares on every granted broadcast.
module tb_int_issue_exec;
   import mips_int_pkg::*;

   typedef struct {
      logic [4:0]  tag;
      logic [31:0] data;
   } exp_t;

   logic Clk;
   logic Rst;
   int   checks = 0;
   int   errors = 0;
   int   cycle  = 0;
   exp_t sb[$];
   int   bcastCycles[$];
   exp_t monE;

   int_issue_exec_if #(.DATA_W(32), .TAG_W(5)) bus ();

   int_issue_exec #(.DATA_W(32), .TAG_W(5)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;
   always @(posedge Clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   // Presents one instruction, waits (bounded) for acceptance, and leaves Ready low afterwards
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                input logic [4:0] shf, input logic [4:0] tag,
                                input logic [31:0] expData, input bit expectOut);
      int waited;
      exp_t e;
      bus.IssueQue_Opcode  = op;
      bus.IssueQue_Rs_Data = rs;
      bus.IssueQue_Rt_Data = rt;
      bus.IssueQue_Shfamt  = shf;
      bus.IssueQue_Rd_Tag  = tag;
      bus.IssueQue_Ready   = 1'b1;
      waited = 0;
      @(negedge Clk);
      while (!bus.Issueblk_Issue && waited < 20) begin
         waited++;
         @(negedge Clk);
      end
      checkOutput("issue_ack", {31'd0, bus.Issueblk_Issue}, 32'd1);
      if (!bus.Issueblk_Issue) begin
         bus.IssueQue_Ready = 1'b0;
         return;
      end
      if (expectOut) begin
         e.tag  = tag;
         e.data = expData;
         sb.push_back(e);
      end
      @(posedge Clk);
      #1;
      bus.IssueQue_Ready = 1'b0;
   endtask

   always @(negedge Clk) begin
      if (!Rst && bus.Int_Cdb_Req && bus.Cdb_Grant && !bus.RB_Flush_Valid) begin
         bcastCycles.push_back(cycle);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_bcast: got tag %0d data %h, required no broadcast",
                     bus.Int_Cdb_Tag, bus.Int_Cdb_Data);
         end else begin
            monE = sb.pop_front();
            checkOutput("cdb_tag", {27'd0, bus.Int_Cdb_Tag}, {27'd0, monE.tag});
            checkOutput("cdb_data", bus.Int_Cdb_Data, monE.data);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   logic [2:0]  edgeOp[7];
   logic [31:0] edgeRs[7];
   logic [31:0] edgeRt[7];
   logic [4:0]  edgeShf[7];
   logic [31:0] edgeExp[7];

   initial begin
      Rst = 1'b1;
      bus.IssueQue_Ready   = 1'b1;
      bus.IssueQue_Rs_Data = 32'h1;
      bus.IssueQue_Rt_Data = 32'h1;
      bus.IssueQue_Rd_Tag  = 5'd1;
      bus.IssueQue_Opcode  = ALU_ADD;
      bus.IssueQue_Shfamt  = 5'd0;
      bus.Cdb_Grant        = 1'b1;
      bus.RB_Flush_Valid   = 1'b0;

      // Held in reset with Ready high: nothing may issue or broadcast
      @(negedge Clk);
      checkOutput("rst_issue", {31'd0, bus.Issueblk_Issue}, 32'd0);
      checkOutput("rst_req",   {31'd0, bus.Int_Cdb_Req}, 32'd0);
      checkOutput("rst_tag",   {27'd0, bus.Int_Cdb_Tag}, 32'd0);
      checkOutput("rst_data",  bus.Int_Cdb_Data, 32'd0);
      #2;
      Rst = 1'b0;
      bus.IssueQue_Ready = 1'b0;
      @(posedge Clk);
      #1;

      $display("[TB] ADD latency");
      applyStimulus(ALU_ADD, 32'd5, 32'd7, 5'd0, 5'd3, 32'd12, 1'b1);
      @(negedge Clk);
      checkOutput("add_lat_c1", {31'd0, bus.Int_Cdb_Req}, 32'd0);
      @(negedge Clk);
      checkOutput("add_lat_c2", {31'd0, bus.Int_Cdb_Req}, 32'd1);
      @(negedge Clk);
      checkOutput("add_after", {31'd0, bus.Int_Cdb_Req}, 32'd0);
      @(posedge Clk);
      #1;

      $display("[TB] backpressure");
      bus.Cdb_Grant = 1'b0;
      applyStimulus(ALU_ADD, 32'd1, 32'd2, 5'd0, 5'd10, 32'd3, 1'b1);
      applyStimulus(ALU_OR, 32'h000000F0, 32'h0000000F, 5'd0, 5'd11, 32'h000000FF, 1'b1);
      bus.IssueQue_Opcode  = ALU_AND;
      bus.IssueQue_Rs_Data = 32'hFF00FF00;
      bus.IssueQue_Rt_Data = 32'h0FF00FF0;
      bus.IssueQue_Rd_Tag  = 5'd12;
      bus.IssueQue_Ready   = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge Clk);
         checkOutput("bp_issue", {31'd0, bus.Issueblk_Issue}, 32'd0);
         checkOutput("bp_req",   {31'd0, bus.Int_Cdb_Req}, 32'd1);
         checkOutput("bp_tag",   {27'd0, bus.Int_Cdb_Tag}, 32'd10);
         checkOutput("bp_data",  bus.Int_Cdb_Data, 32'd3);
      end
      @(posedge Clk);
      #1;
      bus.Cdb_Grant = 1'b1;
      applyStimulus(ALU_AND, 32'hFF00FF00, 32'h0FF00FF0, 5'd0, 5'd12, 32'h0F000F00, 1'b1);
      repeat (4) @(negedge Clk);
      checkOutput("bp_drained", sb.size(), 32'd0);
      @(posedge Clk);
      #1;

      $display("[TB] arithmetic edge cases");
      edgeOp  = '{ALU_SUB, ALU_ADD, ALU_SLT, ALU_SLT, ALU_SRA, ALU_SLL, ALU_SRL};
      edgeRs  = '{32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'h12345678, 32'h12345678, 32'h12345678};
      edgeRt  = '{32'd1, 32'd1, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'd1, 32'h80000000};
      edgeShf = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd31, 5'd4};
`ifdef INT_EXEC_SHIFT_EN
      edgeExp = '{32'hFFFFFFFF, 32'd0, 32'd1, 32'd0, 32'hF8000000, 32'h80000000, 32'h08000000};
`else
      edgeExp = '{32'hFFFFFFFF, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
`endif
      for (int i = 0; i < 7; i++)
         applyStimulus(edgeOp[i], edgeRs[i], edgeRt[i], edgeShf[i], 5'(i + 1), edgeExp[i], 1'b1);
      repeat (4) @(negedge Clk);
      checkOutput("edge_drained", sb.size(), 32'd0);
      @(posedge Clk);
      #1;

      $display("[TB] flush");
      bus.Cdb_Grant = 1'b0;
      applyStimulus(ALU_ADD, 32'd1, 32'd1, 5'd0, 5'd20, 32'd2, 1'b0);
      applyStimulus(ALU_ADD, 32'd2, 32'd2, 5'd0, 5'd21, 32'd4, 1'b0);
      bus.RB_Flush_Valid  = 1'b1;
      bus.Cdb_Grant       = 1'b1;
      bus.IssueQue_Rd_Tag = 5'd22;
      bus.IssueQue_Ready  = 1'b1;
      @(negedge Clk);
      checkOutput("flush_issue",   {31'd0, bus.Issueblk_Issue}, 32'd0);
      checkOutput("flush_wb_full", {31'd0, bus.Int_Cdb_Req}, 32'd1);
      @(posedge Clk);
      #1;
      bus.RB_Flush_Valid = 1'b0;
      bus.IssueQue_Ready = 1'b0;
      @(negedge Clk);
      checkOutput("flush_req", {31'd0, bus.Int_Cdb_Req}, 32'd0);
      @(negedge Clk);
      checkOutput("flush_ex_gone", {31'd0, bus.Int_Cdb_Req}, 32'd0);
      @(posedge Clk);
      #1;

      $display("[TB] asynchronous reset mid-stream");
      bus.Cdb_Grant = 1'b0;
      applyStimulus(ALU_ADD, 32'd20, 32'd22, 5'd0, 5'd25, 32'd42, 1'b1);
      bus.IssueQue_Rd_Tag = 5'd26;
      bus.IssueQue_Ready  = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      checkOutput("rst_pre_req", {31'd0, bus.Int_Cdb_Req}, 32'd1);
      #2;
      Rst = 1'b1;
      #1;
      checkOutput("arst_req",   {31'd0, bus.Int_Cdb_Req}, 32'd0);
      checkOutput("arst_issue", {31'd0, bus.Issueblk_Issue}, 32'd0);
      checkOutput("arst_tag",   {27'd0, bus.Int_Cdb_Tag}, 32'd0);
      checkOutput("arst_data",  bus.Int_Cdb_Data, 32'd0);
      sb.delete();
      bus.IssueQue_Ready = 1'b0;
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      bus.Cdb_Grant = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge Clk);
         checkOutput("rst_empty", {31'd0, bus.Int_Cdb_Req}, 32'd0);
      end
      @(posedge Clk);
      #1;

      $display("[TB] throughput");
      bcastCycles.delete();
      for (int i = 0; i < 10; i++)
         applyStimulus(ALU_ADD, 32'(i), 32'd100, 5'd0, 5'(i), 32'(i + 100), 1'b1);
      repeat (4) @(negedge Clk);
      checkOutput("tp_count", bcastCycles.size(), 32'd10);
      if (bcastCycles.size() == 10)
         for (int i = 1; i < 10; i++)
            checkOutput("tp_gap", 32'(bcastCycles[i] - bcastCycles[i-1]), 32'd1);

      checkOutput("sb_empty", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
